// File: rtl/mips_id_stage_pipe.sv
// MIPS instruction-decode stage: register file with write-back bypass, main
// control decode, sign extension, load-use stall and an ID/EX register with valid/ready flow.
module mips_id_stage_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int IMM_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [31:0]           if_pc,
  input  logic [31:0]           if_inst,
  output logic                  id_ready,
  input  logic                  ex_ready,
  output logic                  ex_valid,
  output logic [31:0]           ex_pc,
  output logic [DATA_W-1:0]     ex_rd1,
  output logic [DATA_W-1:0]     ex_rd2,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic [6:0]            ex_ctrl,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data
);

  localparam int NREG = 1 << REG_ADDR_W;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  // ctrl bit positions: {regwrite, memread, memwrite, memtoreg, alusrc, branch, illegal}
  localparam int C_REGWRITE = 6;
  localparam int C_MEMREAD  = 5;

  logic [DATA_W-1:0]     r_rf [NREG];

  logic                  r_ex_valid;
  logic [31:0]           r_ex_pc;
  logic [DATA_W-1:0]     r_ex_rd1;
  logic [DATA_W-1:0]     r_ex_rd2;
  logic [DATA_W-1:0]     r_ex_imm;
  logic [REG_ADDR_W-1:0] r_ex_rs;
  logic [REG_ADDR_W-1:0] r_ex_rt;
  logic [REG_ADDR_W-1:0] r_ex_dest;
  logic [6:0]            r_ex_ctrl;

  logic [5:0]            w_op;
  logic [REG_ADDR_W-1:0] w_rs;
  logic [REG_ADDR_W-1:0] w_rt;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [DATA_W-1:0]     w_imm;
  logic [DATA_W-1:0]     w_rd1;
  logic [DATA_W-1:0]     w_rd2;
  logic                  w_wb_hit;
  logic [6:0]            w_ctrl;
  logic [REG_ADDR_W-1:0] w_dest;
  logic                  w_uses_rt;
  logic                  w_stall;
  logic                  w_advance;

  assign w_op  = if_inst[31:26];
  assign w_rs  = if_inst[21 +: REG_ADDR_W];
  assign w_rt  = if_inst[16 +: REG_ADDR_W];
  assign w_rd  = if_inst[11 +: REG_ADDR_W];
  assign w_imm = {{(DATA_W-IMM_W){if_inst[IMM_W-1]}}, if_inst[IMM_W-1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (wb_we && wb_addr != '0) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  // Write-back data is forwarded so an instruction reading a register in the
  // same cycle it is written sees the new value.
  assign w_wb_hit = wb_we && (wb_addr != '0);
  assign w_rd1 = (w_rs == '0) ? '0 :
                 (w_wb_hit && wb_addr == w_rs) ? wb_data : r_rf[w_rs];
  assign w_rd2 = (w_rt == '0) ? '0 :
                 (w_wb_hit && wb_addr == w_rt) ? wb_data : r_rf[w_rt];

  always_comb begin
    w_ctrl    = 7'b0;
    w_dest    = '0;
    w_uses_rt = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_ctrl    = 7'b1000000;
        w_dest    = w_rd;
        w_uses_rt = 1'b1;
      end
      OP_LW: begin
        w_ctrl = 7'b1101100;
        w_dest = w_rt;
      end
      OP_SW: begin
        w_ctrl    = 7'b0010100;
        w_uses_rt = 1'b1;
      end
      OP_ADDI: begin
        w_ctrl = 7'b1000100;
        w_dest = w_rt;
      end
      OP_BEQ: begin
        w_ctrl    = 7'b0000010;
        w_uses_rt = 1'b1;
      end
      default: w_ctrl = 7'b0000001;
    endcase
    if (w_dest == '0) w_ctrl[C_REGWRITE] = 1'b0;
  end

  assign w_stall = r_ex_valid && r_ex_ctrl[C_MEMREAD] && (r_ex_dest != '0) && if_valid &&
                   ((r_ex_dest == w_rs) || (w_uses_rt && r_ex_dest == w_rt));

  assign w_advance = ~r_ex_valid | ex_ready;
  assign id_ready  = w_advance & ~w_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex_valid <= 1'b0;
      r_ex_pc    <= '0;
      r_ex_rd1   <= '0;
      r_ex_rd2   <= '0;
      r_ex_imm   <= '0;
      r_ex_rs    <= '0;
      r_ex_rt    <= '0;
      r_ex_dest  <= '0;
      r_ex_ctrl  <= '0;
    end else if (w_advance && w_stall) begin
      r_ex_valid <= 1'b0;
      r_ex_pc    <= '0;
      r_ex_rd1   <= '0;
      r_ex_rd2   <= '0;
      r_ex_imm   <= '0;
      r_ex_rs    <= '0;
      r_ex_rt    <= '0;
      r_ex_dest  <= '0;
      r_ex_ctrl  <= '0;
    end else if (w_advance) begin
      r_ex_valid <= if_valid;
      r_ex_pc    <= if_pc;
      r_ex_rd1   <= w_rd1;
      r_ex_rd2   <= w_rd2;
      r_ex_imm   <= w_imm;
      r_ex_rs    <= w_rs;
      r_ex_rt    <= w_rt;
      r_ex_dest  <= w_dest;
      r_ex_ctrl  <= w_ctrl;
    end
  end

  assign ex_valid = r_ex_valid;
  assign ex_pc    = r_ex_pc;
  assign ex_rd1   = r_ex_rd1;
  assign ex_rd2   = r_ex_rd2;
  assign ex_imm   = r_ex_imm;
  assign ex_rs    = r_ex_rs;
  assign ex_rt    = r_ex_rt;
  assign ex_dest  = r_ex_dest;
  assign ex_ctrl  = r_ex_ctrl;

endmodule

// File: tb/tb_mips_id_stage_pipe.sv
// Directed table-driven bench for mips_id_stage_pipe, plus a hand-written
// async-reset-during-hold sequence.
module tb_mips_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_rd1;
  logic [31:0] ex_rd2;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_dest;
  logic [6:0]  ex_ctrl;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int errors = 0;
  int checks = 0;
  int cur_row = 0;

  mips_id_stage_pipe #(.DATA_W(32), .REG_ADDR_W(5), .IMM_W(16)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .id_ready(id_ready),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_ctrl(ex_ctrl),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rdy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        idr;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [6:0]  ctrl;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic vec_t mk(
    input logic v, input logic [31:0] pc, input logic [31:0] inst, input logic rdy,
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic idr, input logic ev, input logic [31:0] epc,
    input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
    input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dest, input logic [6:0] ctrl);
    vec_t t;
    t.v = v; t.pc = pc; t.inst = inst; t.rdy = rdy;
    t.we = we; t.wa = wa; t.wd = wd;
    t.idr = idr; t.ev = ev; t.epc = epc;
    t.rd1 = rd1; t.rd2 = rd2; t.imm = imm;
    t.rs = rs; t.rt = rt; t.dest = dest; t.ctrl = ctrl;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row=%0d actual=%h required=%h", name, cur_row, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst, input logic rdy,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    if_valid = v; if_pc = pc; if_inst = inst; ex_ready = rdy;
    wb_we = we; wb_addr = wa; wb_data = wd;
  endtask

  task automatic check_ex(input vec_t t);
    chk("ex_valid", 32'(ex_valid), 32'(t.ev));
    chk("ex_pc",    ex_pc,         t.epc);
    chk("ex_rd1",   ex_rd1,        t.rd1);
    chk("ex_rd2",   ex_rd2,        t.rd2);
    chk("ex_imm",   ex_imm,        t.imm);
    chk("ex_rs",    32'(ex_rs),    32'(t.rs));
    chk("ex_rt",    32'(ex_rt),    32'(t.rt));
    chk("ex_dest",  32'(ex_dest),  32'(t.dest));
    chk("ex_ctrl",  32'(ex_ctrl),  32'(t.ctrl));
  endtask

  task automatic apply(input vec_t t);
    drive(t.v, t.pc, t.inst, t.rdy, t.we, t.wa, t.wd);
    #2;
    chk("id_ready", 32'(id_ready), 32'(t.idr));
    @(posedge clk);
    #1;
    check_ex(t);
    $display("row %0d: v=%0d inst=%h rdy=%0d -> ex_valid=%0d pc=%h rd1=%h rd2=%h imm=%h dest=%0d ctrl=%b",
             cur_row, t.v, t.inst, t.rdy, ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_dest, ex_ctrl);
  endtask

  vec_t zero_v;
  vec_t tmp;

  initial begin
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
    zero_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'h00);

    // v pc inst rdy | we wa wd | idr | ev epc rd1 rd2 imm rs rt dest ctrl
    tbl[0]  = mk(0, 32'h0,  32'h0,                            1, 1, 5'd4, 32'h100,      1, 0, 32'h0,  32'h0,      32'h0,      32'h0,      0, 0, 0, 7'h00);
    tbl[1]  = mk(0, 32'h0,  32'h0,                            1, 1, 5'd7, 32'h7,        1, 0, 32'h0,  32'h0,      32'h0,      32'h0,      0, 0, 0, 7'h00);
    tbl[2]  = mk(1, 32'h10, enc_r(5'd1, 5'd3, 5'd3),          1, 1, 5'd3, 32'hDEADBEEF, 1, 1, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0820, 3, 3, 1, 7'h40);
    tbl[3]  = mk(1, 32'h14, enc_r(5'd5, 5'd0, 5'd3),          1, 1, 5'd0, 32'h1234,     1, 1, 32'h14, 32'h0,      32'hDEADBEEF, 32'h2820,   0, 3, 5, 7'h40);
    tbl[4]  = mk(1, 32'h18, enc_r(5'd0, 5'd3, 5'd4),          1, 0, 5'd0, 32'h0,        1, 1, 32'h18, 32'hDEADBEEF, 32'h100,  32'h0020,   3, 4, 0, 7'h00);
    tbl[5]  = mk(1, 32'h1C, enc_i(6'h23, 5'd4, 5'd2, 16'hFFFC), 1, 0, 5'd0, 32'h0,      1, 1, 32'h1C, 32'h100,    32'h0,      32'hFFFFFFFC, 4, 2, 2, 7'h6C);
    tbl[6]  = mk(1, 32'h20, enc_r(5'd6, 5'd2, 5'd7),          1, 0, 5'd0, 32'h0,        0, 0, 32'h0,  32'h0,      32'h0,      32'h0,      0, 0, 0, 7'h00);
    tbl[7]  = mk(1, 32'h20, enc_r(5'd6, 5'd2, 5'd7),          1, 1, 5'd2, 32'h55,       1, 1, 32'h20, 32'h55,     32'h7,      32'h3020,   2, 7, 6, 7'h40);
    tbl[8]  = mk(1, 32'h24, enc_i(6'h23, 5'd4, 5'd2, 16'h0004), 1, 0, 5'd0, 32'h0,      1, 1, 32'h24, 32'h100,    32'h55,     32'h4,      4, 2, 2, 7'h6C);
    tbl[9]  = mk(1, 32'h28, enc_i(6'h08, 5'd2, 5'd9, 16'h0001), 1, 0, 5'd0, 32'h0,      0, 0, 32'h0,  32'h0,      32'h0,      32'h0,      0, 0, 0, 7'h00);
    tbl[10] = mk(1, 32'h28, enc_i(6'h08, 5'd2, 5'd9, 16'h0001), 1, 0, 5'd0, 32'h0,      1, 1, 32'h28, 32'h55,     32'h0,      32'h1,      2, 9, 9, 7'h44);
    tbl[11] = mk(1, 32'h2C, enc_i(6'h23, 5'd0, 5'd2, 16'h0008), 1, 0, 5'd0, 32'h0,      1, 1, 32'h2C, 32'h0,      32'h55,     32'h8,      0, 2, 2, 7'h6C);
    tbl[12] = mk(1, 32'h30, enc_i(6'h2B, 5'd4, 5'd2, 16'h0000), 1, 0, 5'd0, 32'h0,      0, 0, 32'h0,  32'h0,      32'h0,      32'h0,      0, 0, 0, 7'h00);
    tbl[13] = mk(1, 32'h30, enc_i(6'h2B, 5'd4, 5'd2, 16'h0000), 1, 0, 5'd0, 32'h0,      1, 1, 32'h30, 32'h100,    32'h55,     32'h0,      4, 2, 0, 7'h14);
    tbl[14] = mk(1, 32'h34, enc_i(6'h23, 5'd4, 5'd2, 16'h0000), 1, 0, 5'd0, 32'h0,      1, 1, 32'h34, 32'h100,    32'h55,     32'h0,      4, 2, 2, 7'h6C);
    tbl[15] = mk(1, 32'h38, enc_i(6'h08, 5'd4, 5'd2, 16'hFFFF), 1, 0, 5'd0, 32'h0,      1, 1, 32'h38, 32'h100,    32'h55,     32'hFFFFFFFF, 4, 2, 2, 7'h44);
    tbl[16] = mk(1, 32'h3C, enc_i(6'h3F, 5'd1, 5'd3, 16'h8000), 1, 0, 5'd0, 32'h0,      1, 1, 32'h3C, 32'h0,      32'hDEADBEEF, 32'hFFFF8000, 1, 3, 0, 7'h01);
    tbl[17] = mk(1, 32'h40, enc_i(6'h04, 5'd3, 5'd4, 16'h0010), 1, 0, 5'd0, 32'h0,      1, 1, 32'h40, 32'hDEADBEEF, 32'h100,  32'h10,     3, 4, 0, 7'h02);
    tbl[18] = mk(1, 32'h44, enc_r(5'd8, 5'd4, 5'd7),          1, 0, 5'd0, 32'h0,        1, 1, 32'h44, 32'h100,    32'h7,      32'h4020,   4, 7, 8, 7'h40);
    tbl[19] = mk(1, 32'h48, enc_r(5'd10, 5'd7, 5'd7),         0, 0, 5'd0, 32'h0,        0, 1, 32'h44, 32'h100,    32'h7,      32'h4020,   4, 7, 8, 7'h40);
    tbl[20] = mk(1, 32'h48, enc_r(5'd10, 5'd7, 5'd7),         0, 0, 5'd0, 32'h0,        0, 1, 32'h44, 32'h100,    32'h7,      32'h4020,   4, 7, 8, 7'h40);
    tbl[21] = mk(1, 32'h48, enc_r(5'd10, 5'd7, 5'd7),         0, 0, 5'd0, 32'h0,        0, 1, 32'h44, 32'h100,    32'h7,      32'h4020,   4, 7, 8, 7'h40);
    tbl[22] = mk(1, 32'h48, enc_r(5'd10, 5'd7, 5'd7),         1, 0, 5'd0, 32'h0,        1, 1, 32'h48, 32'h7,      32'h7,      32'h5020,   7, 7, 10, 7'h40);
    tbl[23] = mk(0, 32'h0,  32'h0,                            1, 0, 5'd0, 32'h0,        1, 0, 32'h0,  32'h0,      32'h0,      32'h0,      0, 0, 0, 7'h00);

    // Reset state while held in reset
    #12;
    cur_row = -1;
    chk("rst_id_ready", 32'(id_ready), 32'h1);
    check_ex(zero_v);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      cur_row = i;
      apply(tbl[i]);
    end

    // Write r5, capture a reader under backpressure, then reset mid-hold
    cur_row = 100;
    tmp = mk(0, 32'h0, 32'h0, 1, 1, 5'd5, 32'h77, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 7'h00);
    apply(tmp);
    cur_row = 101;
    tmp = mk(1, 32'h60, enc_r(5'd1, 5'd5, 5'd0), 0, 0, 5'd0, 32'h0, 1, 1, 32'h60, 32'h77, 32'h0, 32'h0820, 5, 0, 1, 7'h40);
    apply(tmp);
    cur_row = 102;
    drive(1'b1, 32'h64, enc_r(5'd2, 5'd5, 5'd5), 1'b0, 1'b0, 5'd0, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_id_ready", 32'(id_ready), 32'h1);
    check_ex(zero_v);
    $display("row %0d: async reset during hold -> ex_valid=%0d ex_pc=%h", cur_row, ex_valid, ex_pc);
    @(negedge clk);
    rst = 1'b1;
    cur_row = 103;
    tmp = mk(1, 32'h68, enc_r(5'd1, 5'd5, 5'd5), 1, 0, 5'd0, 32'h0, 1, 1, 32'h68, 32'h0, 32'h0, 32'h0820, 5, 5, 1, 7'h40);
    apply(tmp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_id_stage_pipe.md
Name: mips_id_stage_pipe

Overview:
- Parametrised MIPS instruction-decode stage that supersedes the flat combinational decode block.
- Contains a multi-entry register file with a write-back port and same-cycle write-to-read bypass, a main-control decoder and a sign extender.
- Adds an ID/EX pipeline register with a valid/ready handshake and load-use hazard detection that inserts bubbles.
- Sits between the IF stage (upstream) and the EX stage (downstream); write-back arrives from the WB stage.

Parameters:
DATA_W, 32, register/data width; sign extension fills to this width
REG_ADDR_W, 5, register index width; file holds 2**REG_ADDR_W entries
IMM_W, 16, immediate field width taken from inst[IMM_W-1:0]; must be less than DATA_W

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
if_valid  in  1  IF presents a valid instruction
if_pc  in  32  PC of the presented instruction
if_inst  in  32  presented instruction word
id_ready  out  1  ID accepts the IF instruction this cycle
ex_ready  in  1  EX accepts the ID/EX contents this cycle
ex_valid  out  1  ID/EX register holds a valid instruction
ex_pc  out  32  registered PC
ex_rd1  out  DATA_W  registered rs operand
ex_rd2  out  DATA_W  registered rt operand
ex_imm  out  DATA_W  registered sign-extended immediate
ex_rs  out  REG_ADDR_W  registered rs index
ex_rt  out  REG_ADDR_W  registered rt index
ex_dest  out  REG_ADDR_W  registered destination index
ex_ctrl  out  7  {regwrite, memread, memwrite, memtoreg, alusrc, branch, illegal}, registered
wb_we  in  1  write-back enable
wb_addr  in  REG_ADDR_W  write-back register index
wb_data  in  DATA_W  write-back data

Behaviour:
- Reset (rst=0, asynchronous):
  - All register-file entries are cleared to 0.
  - ex_valid=0; all ex_* data, index and ctrl outputs are 0.
  - id_ready follows its combinational equation.
- Register file:
  - Write occurs on the rising clk edge when wb_we=1 and wb_addr!=0.
  - Entry 0 always reads 0; writes to entry 0 are ignored.
  - Reads are combinational.
  - Bypass: if wb_we=1, wb_addr!=0 and wb_addr equals the read index, the read returns wb_data in the same cycle.
- Decode, on opcode inst[31:26]; rs=inst[25:21], rt=inst[20:16], rd=inst[15:11] (low REG_ADDR_W bits used):
  - 0x00 R-type: regwrite=1, dest=rd.
  - 0x23 lw: regwrite, memread, memtoreg, alusrc; dest=rt.
  - 0x2B sw: memwrite, alusrc; dest=0.
  - 0x08 addi: regwrite, alusrc; dest=rt.
  - 0x04 beq: branch; dest=0.
  - Any other opcode: illegal=1, all other ctrl bits 0, dest=0.
  - If the computed dest=0, regwrite is forced to 0.
- Sign extension: ex_imm = inst[IMM_W-1] replicated to DATA_W, concatenated with inst[IMM_W-1:0].
- Hazard: stall=1 when all of the following hold:
  - ex_valid=1, ex_ctrl.memread=1 and ex_dest!=0;
  - if_valid=1;
  - ex_dest==rs, or ex_dest==rt with the IF opcode in {R-type, sw, beq}.
- Handshake (all combinational, then registered on the clock edge):
  - advance = ~ex_valid | ex_ready.
  - id_ready = advance & ~stall.
  - advance & stall: the ID/EX register loads a bubble (ex_valid=0, ctrl=0, other fields 0). The IF instruction is not consumed.
  - advance & ~stall: ex_valid<=if_valid; all fields are captured from the current decode and register-file reads (bypass included).
  - ~advance: the ID/EX register holds every field unchanged.
- Latency: one cycle from acceptance to ex_valid.
- Throughput: one instruction per cycle with no stall.
- A load-use dependency costs exactly one bubble cycle.
- Reset asserted mid-stall or mid-hold discards all in-flight state.

Test Plan:
- Reset: write regs, assert rst=0 mid-run -> ex_valid=0, all ex_* = 0; after release, reading r5 returns 0.
- Bypass: wb_we=1, wb_addr=3, wb_data=0xDEADBEEF, same cycle if_inst=add r1,r3,r3 -> next cycle ex_rd1=ex_rd2=0xDEADBEEF, ex_dest=1, regwrite=1.
- r0: wb write 0x1234 to r0, then decode rs=0 -> ex_rd1=0. R-type with rd=0 -> regwrite=0.
- Sign-extend and controls: lw r2,0xFFFC(r4) -> ex_imm=0xFFFFFFFC, ctrl={1,1,0,1,1,0,0}, ex_dest=2. Opcode 0x3F -> illegal=1, other ctrl bits 0.
- Load-use: lw r2 followed by add r6,r2,r7 with ex_ready=1 -> one cycle with id_ready=0 and ex_valid=0 (bubble), then add issues. addi r9,r2,1 after lw r2 also stalls (rs match). sw with rt=2 after lw r2 stalls.
- Backpressure: ex_ready=0 for 3 cycles with ex_valid=1 -> id_ready=0 and all ex_* held stable. On ex_ready=1, the pending instruction is captured the next cycle with no loss or duplication.
